// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared types and constants for the switch port arbiter
package switch_pkg;

    localparam int NPORT = 4;
    localparam int ADR_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    // bit offsets of source n within the packed per-source buses
    function automatic int adr_lsb(input int n);
        return ADR_W * n;
    endfunction

    function automatic int dat_lsb(input int n, input int dw);
        return dw * n;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way round-robin picker
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic       o_any,
    output logic [1:0] o_idx
);

    logic [7:0] w_dbl;
    logic [3:0] w_rot;
    logic [1:0] w_off;

    // rotate so i_ptr lands on bit 0, then take the lowest set bit
    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[i_ptr +: 4];
    assign o_any = |i_req;

    always_comb begin
        w_off = 2'd0;
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
    end

    assign o_idx = i_ptr + w_off;

endmodule

// File: rtl/switch_port_arbiter.sv
// rtl/switch_port_arbiter.sv - per-destination-port round-robin arbiter with ack timeout
module switch_port_arbiter
    import switch_pkg::*;
#(
    parameter int               DW      = 4,
    parameter logic [ADR_W-1:0] PORT_ID = 2'd0,
    parameter int               TIMEOUT = 16
) (
    input  logic                  clk_i2,
    input  logic                  rst_i,
    input  logic [NPORT-1:0]      req_valid_i,
    input  logic [NPORT*ADR_W-1:0] req_adr_i,
    input  logic [NPORT*DW-1:0]   req_dat_i,
    output logic [NPORT-1:0]      req_ack_o,
    output logic                  dst_valid_o,
    output logic [DW-1:0]         dst_dat_o,
    output logic [1:0]            dst_src_o,
    input  logic                  dst_ack_i,
    output logic                  timeout_o
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_rr_ptr;
    logic [1:0]       r_grant;
    logic [7:0]       r_tmo_cnt;
    logic             r_dst_valid;
    logic [DW-1:0]    r_dst_dat;
    logic [NPORT-1:0] r_req_ack;
    logic             r_timeout;

    logic [NPORT-1:0] w_elig;
    logic             w_any;
    logic [1:0]       w_idx;
    logic [DW-1:0]    w_sel_dat;
    logic             w_tmo_hit;
    logic             w_grant_valid;

    always_comb begin
        w_elig = '0;
        for (int n = 0; n < NPORT; n++) begin
            w_elig[n] = req_valid_i[n] & (req_adr_i[adr_lsb(n) +: ADR_W] == PORT_ID);
        end
    end

    rr_pick4 u_pick (
        .i_req (w_elig),
        .i_ptr (r_rr_ptr),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    assign w_sel_dat     = req_dat_i[dat_lsb(int'(w_idx), DW) +: DW];
    assign w_tmo_hit     = (r_tmo_cnt == 8'(TIMEOUT - 1));
    assign w_grant_valid = req_valid_i[r_grant];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = SEND;
            SEND: begin
                // an ack arriving on the final timeout cycle takes priority
                if (dst_ack_i)      w_state_nxt = ACK;
                else if (w_tmo_hit) w_state_nxt = IDLE;
            end
            ACK:     if (!w_grant_valid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i2) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i2) begin
        if (rst_i) begin
            r_rr_ptr    <= 2'd0;
            r_grant     <= 2'd0;
            r_tmo_cnt   <= 8'd0;
            r_dst_valid <= 1'b0;
            r_dst_dat   <= '0;
            r_req_ack   <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_dst_valid <= 1'b0;
                    if (w_any) begin
                        r_grant     <= w_idx;
                        r_dst_dat   <= w_sel_dat;
                        r_dst_valid <= 1'b1;
                        r_tmo_cnt   <= 8'd0;
                    end
                end
                SEND: begin
                    if (dst_ack_i) begin
                        r_dst_valid <= 1'b0;
                        r_req_ack   <= NPORT'(1) << r_grant;
                    end else if (w_tmo_hit) begin
                        r_dst_valid <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_rr_ptr    <= r_grant + 2'd1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                ACK: begin
                    if (!w_grant_valid) begin
                        r_req_ack <= '0;
                        r_rr_ptr  <= r_grant + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ack_o   = r_req_ack;
    assign dst_valid_o = r_dst_valid;
    assign dst_dat_o   = r_dst_dat;
    assign dst_src_o   = r_grant;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_switch_port_arbiter.sv
// tb/tb_switch_port_arbiter.sv - scoreboard bench for switch_port_arbiter (PORT_ID=1, TIMEOUT=16)
module tb_switch_port_arbiter;

    localparam int DW = 4;

    logic        clk_i2 = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  req_valid_i = '0;
    logic [7:0]  req_adr_i = '0;
    logic [15:0] req_dat_i = '0;
    logic        dst_ack_i = 1'b0;
    logic [3:0]  req_ack_o;
    logic        dst_valid_o;
    logic [3:0]  dst_dat_o;
    logic [1:0]  dst_src_o;
    logic        timeout_o;

    always #5 clk_i2 = ~clk_i2;

    switch_port_arbiter #(.DW(DW), .PORT_ID(2'd1), .TIMEOUT(16)) dut (
        .clk_i2      (clk_i2),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_adr_i   (req_adr_i),
        .req_dat_i   (req_dat_i),
        .req_ack_o   (req_ack_o),
        .dst_valid_o (dst_valid_o),
        .dst_dat_o   (dst_dat_o),
        .dst_src_o   (dst_src_o),
        .dst_ack_i   (dst_ack_i),
        .timeout_o   (timeout_o)
    );

    typedef struct packed {
        logic [1:0] src;
        logic [3:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk_i2);
    endtask

    task automatic push(input logic [1:0] s, input logic [3:0] d);
        exp_t e;
        e.src = s;
        e.dat = d;
        exp_q.push_back(e);
    endtask

    task automatic set_src(input int n, input logic v, input logic [1:0] a, input logic [3:0] d);
        req_valid_i[n]        = v;
        req_adr_i[2*n +: 2]   = a;
        req_dat_i[DW*n +: DW] = d;
    endtask

    task automatic do_reset();
        req_valid_i = '0;
        dst_ack_i   = 1'b0;
        rst_i       = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int k;
        k = 0;
        while (dst_valid_o !== 1'b1 && k < 64) begin
            tick();
            k++;
        end
        check({nm, "_valid_seen"}, 32'(dst_valid_o), 1);
    endtask

    task automatic complete(input int src, input int dly, input int hold, input bit restore);
        repeat (dly) tick();
        dst_ack_i = 1'b1;
        tick();
        dst_ack_i = 1'b0;
        check("ack_rise", 32'(req_ack_o), 32'(4'b0001 << src));
        check("valid_fall", 32'(dst_valid_o), 0);
        repeat (hold) begin
            tick();
            check("ack_hold", 32'(req_ack_o), 32'(4'b0001 << src));
        end
        req_valid_i[src] = 1'b0;
        tick();
        check("ack_fall", 32'(req_ack_o), 0);
        if (restore) req_valid_i[src] = 1'b1;
    endtask

    // monitor: pops the scoreboard on each new transfer and checks invariants every cycle
    logic       pv = 1'b0;
    logic [1:0] ps = '0;
    logic [3:0] pd = '0;
    always @(negedge clk_i2) begin : monitor
        exp_t e;
        if (mon_en) begin
            check("no_valid_with_ack", 32'(dst_valid_o && (req_ack_o != 4'd0)), 0);
            check("ack_onehot0", 32'($onehot0(req_ack_o)), 1);
            if (dst_valid_o && !pv) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got src %0d expected no transfer", dst_src_o);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_src", 32'(dst_src_o), 32'(e.src));
                    check("grant_dat", 32'(dst_dat_o), 32'(e.dat));
                end
            end else if (dst_valid_o && pv) begin
                check("hold_src", 32'(dst_src_o), 32'(ps));
                check("hold_dat", 32'(dst_dat_o), 32'(pd));
            end
            pv = dst_valid_o;
            ps = dst_src_o;
            pd = dst_dat_o;
        end
    end

    initial begin : stim
        int  k;
        bit  seen;

        do_reset();
        check("rst_valid", 32'(dst_valid_o), 0);
        check("rst_ack", 32'(req_ack_o), 0);
        check("rst_dat", 32'(dst_dat_o), 0);
        check("rst_src", 32'(dst_src_o), 0);
        check("rst_tmo", 32'(timeout_o), 0);
        mon_en = 1'b1;

        // reset during SEND restores rr_ptr to 0
        set_src(2, 1'b1, 2'd1, 4'hA);
        push(2'd2, 4'hA);
        wait_valid("t1a");
        complete(2, 1, 0, 1'b0);
        set_src(3, 1'b1, 2'd1, 4'hB);
        push(2'd3, 4'hB);
        wait_valid("t1b");
        rst_i = 1'b1;
        set_src(0, 1'b1, 2'd1, 4'hC);
        tick();
        rst_i = 1'b0;
        check("rst_mid_valid", 32'(dst_valid_o), 0);
        check("rst_mid_ack", 32'(req_ack_o), 0);
        push(2'd0, 4'hC);
        wait_valid("t1c");
        complete(0, 0, 0, 1'b0);
        do_reset();

        // single source, delayed sink ack, source holds valid two extra cycles
        set_src(2, 1'b1, 2'd1, 4'h5);
        push(2'd2, 4'h5);
        wait_valid("t2");
        complete(2, 3, 2, 1'b0);
        do_reset();

        // no source addresses this port
        set_src(0, 1'b1, 2'd0, 4'h1);
        set_src(1, 1'b1, 2'd2, 4'h2);
        set_src(2, 1'b1, 2'd3, 4'h3);
        set_src(3, 1'b1, 2'd0, 4'h4);
        seen = 1'b0;
        repeat (50) begin
            tick();
            if (dst_valid_o || req_ack_o != 4'd0) seen = 1'b1;
        end
        check("filter_idle", 32'(seen), 0);
        do_reset();

        // round-robin fairness with immediate acks
        for (int n = 0; n < 4; n++) set_src(n, 1'b1, 2'd1, 4'(n + 4));
        push(2'd0, 4'h4); push(2'd1, 4'h5); push(2'd2, 4'h6);
        push(2'd3, 4'h7); push(2'd0, 4'h4); push(2'd1, 4'h5);
        for (int j = 0; j < 6; j++) begin
            wait_valid("t4");
            complete(j % 4, 0, 0, (j < 5));
        end
        do_reset();

        // timeout drops source 1 and advances rr_ptr to 2
        set_src(1, 1'b1, 2'd1, 4'h7);
        set_src(2, 1'b1, 2'd1, 4'h9);
        push(2'd1, 4'h7);
        wait_valid("t5");
        k = 0;
        seen = 1'b0;
        while (dst_valid_o && k < 40) begin
            tick();
            k++;
            if (req_ack_o != 4'd0) seen = 1'b1;
        end
        check("tmo_cycles", 32'(k), 16);
        check("tmo_pulse", 32'(timeout_o), 1);
        check("tmo_no_ack", 32'(seen), 0);
        push(2'd2, 4'h9);
        tick();
        check("tmo_one_cycle", 32'(timeout_o), 0);
        wait_valid("t5b");
        complete(2, 0, 0, 1'b0);
        do_reset();

        // ack on the final timeout cycle wins
        set_src(1, 1'b1, 2'd1, 4'hC);
        push(2'd1, 4'hC);
        wait_valid("t6");
        repeat (15) tick();
        check("coll_pre_valid", 32'(dst_valid_o), 1);
        dst_ack_i = 1'b1;
        tick();
        dst_ack_i = 1'b0;
        check("coll_no_tmo", 32'(timeout_o), 0);
        check("coll_ack", 32'(req_ack_o), 32'(4'b0010));
        req_valid_i[1] = 1'b0;
        tick();
        check("coll_ack_fall", 32'(req_ack_o), 0);
        do_reset();

        repeat (4) tick();
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
